// File: rtl/wb_shared_bus.sv
// Purpose: Wishbone B4 classic shared bus, N masters to N slaves, round-robin arbitration, base/mask decode, bus-error generation.
// Latency: grant one cycle after a request is seen in IDLE; slave ack/err/data reach the master combinationally.
// Backpressure: slaves stall by withholding ack; a stall longer than TIMEOUT_CYCLES, or an unmapped address, is ended with an error.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i            per-master cycle, strobe, write enable
//   m_adr_i/m_dat_i/m_sel_i           per-master address, write data, byte selects (flat)
//   m_ack_o/m_err_o, m_dat_o          per-master ack/err, broadcast read data
//   s_cyc_o/s_stb_o                   per-slave cycle/strobe (selected slave only)
//   s_we_o/s_adr_o/s_dat_o/s_sel_o    broadcast from the bus owner
//   s_ack_i/s_err_i/s_dat_i           per-slave responses
//   grant_o                           one-hot owner, 0 when idle
//   bus_err_o, err_cause_o, err_adr_o interconnect error pulse and last-error record
module wb_shared_bus #(
   parameter int                     N_MASTERS      = 2,
   parameter int                     N_SLAVES       = 4,
   parameter logic [N_SLAVES*32-1:0] SLAVE_BASE     = {32'h0000_9200, 32'h0000_9100, 32'h0000_9000, 32'h0000_0000},
   parameter logic [N_SLAVES*32-1:0] SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_8000},
   parameter int                     TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [N_MASTERS-1:0]    m_cyc_i,
   input  logic [N_MASTERS-1:0]    m_stb_i,
   input  logic [N_MASTERS-1:0]    m_we_i,
   input  logic [N_MASTERS*32-1:0] m_adr_i,
   input  logic [N_MASTERS*32-1:0] m_dat_i,
   input  logic [N_MASTERS*4-1:0]  m_sel_i,
   output logic [N_MASTERS-1:0]    m_ack_o,
   output logic [N_MASTERS-1:0]    m_err_o,
   output logic [31:0]             m_dat_o,
   output logic [N_SLAVES-1:0]     s_cyc_o,
   output logic [N_SLAVES-1:0]     s_stb_o,
   output logic                    s_we_o,
   output logic [31:0]             s_adr_o,
   output logic [31:0]             s_dat_o,
   output logic [3:0]              s_sel_o,
   input  logic [N_SLAVES-1:0]     s_ack_i,
   input  logic [N_SLAVES-1:0]     s_err_i,
   input  logic [N_SLAVES*32-1:0]  s_dat_i,
   output logic [N_MASTERS-1:0]    grant_o,
   output logic                    bus_err_o,
   output logic [1:0]              err_cause_o,
   output logic [31:0]             err_adr_o
);

   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state, state_nxt;
   logic [MW-1:0]  owner, owner_nxt;
   logic [MW-1:0]  last, last_nxt;
   logic           err_r;
   logic [15:0]    tmo_cnt;

   logic           busy;
   logic           o_cyc, o_stb, o_we;
   logic [31:0]    o_adr, o_dat;
   logic [3:0]     o_sel;
   logic           hit;
   logic [SW-1:0]  hit_idx;
   logic           sl_ack, sl_err;
   logic [31:0]    sl_dat;
   logic           o_req, miss_fire, tmo_inc, tmo_fire;

   assign busy  = (state == BUSY);
   assign o_cyc = m_cyc_i[owner];
   assign o_stb = m_stb_i[owner];
   assign o_we  = m_we_i[owner];
   assign o_adr = m_adr_i[owner*32 +: 32];
   assign o_dat = m_dat_i[owner*32 +: 32];
   assign o_sel = m_sel_i[owner*4 +: 4];

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((o_adr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   assign sl_ack = s_ack_i[hit_idx];
   assign sl_err = s_err_i[hit_idx];
   assign sl_dat = s_dat_i[hit_idx*32 +: 32];

   assign o_req     = busy & o_cyc & o_stb;
   assign miss_fire = o_req & ~hit & ~err_r;
   // The wait counter is frozen during the error pulse: the slave strobe is
   // gated off then, so the slave has no chance to answer.
   assign tmo_inc   = o_req & hit & ~sl_ack & ~sl_err & ~err_r;
   assign tmo_fire  = (TIMEOUT_CYCLES != 0) && tmo_inc && (tmo_cnt == TMO_LAST);

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      case (state)
         IDLE: begin
            // Round robin: first requester strictly after the previous owner.
            for (int k = N_MASTERS; k >= 1; k--) begin
               if (m_cyc_i[(int'(last) + k) % N_MASTERS]) begin
                  owner_nxt = MW'((int'(last) + k) % N_MASTERS);
                  last_nxt  = MW'((int'(last) + k) % N_MASTERS);
                  state_nxt = BUSY;
               end
            end
         end
         BUSY: begin
            if (!o_cyc) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         owner       <= '0;
         last        <= MW'(N_MASTERS - 1);
         err_r       <= 1'b0;
         err_cause_o <= 2'b00;
         err_adr_o   <= '0;
         tmo_cnt     <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         err_r <= miss_fire | tmo_fire;
         if (miss_fire) begin
            err_cause_o <= 2'b01;
            err_adr_o   <= o_adr;
         end else if (tmo_fire) begin
            err_cause_o <= 2'b10;
            err_adr_o   <= o_adr;
         end
         if (tmo_inc && !tmo_fire) begin
            tmo_cnt <= tmo_cnt + 16'd1;
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   always_comb begin
      grant_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      m_dat_o = '0;
      s_cyc_o = '0;
      s_stb_o = '0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      if (busy) begin
         grant_o[owner] = 1'b1;
         s_we_o         = o_we;
         s_adr_o        = o_adr;
         s_dat_o        = o_dat;
         s_sel_o        = o_sel;
         if (hit) begin
            s_cyc_o[hit_idx] = o_cyc;
            s_stb_o[hit_idx] = o_stb & ~err_r;
            m_ack_o[owner]   = sl_ack;
            m_dat_o          = sl_dat;
         end
         m_err_o[owner] = (hit & sl_err) | err_r;
      end
   end

   assign bus_err_o = err_r;

endmodule

// File: tb/tb_wb_shared_bus.sv
// Purpose: directed bench for wb_shared_bus (2 masters, 4 slaves, timeout 8).
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: bench slaves ack combinationally unless masked per slave.
module tb_wb_shared_bus;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [63:0] m_adr, m_dat;
   logic [7:0]  m_sel;
   logic [1:0]  m_ack_o, m_err_o;
   logic [31:0] m_dat_o;
   logic [3:0]  s_cyc_o, s_stb_o;
   logic        s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [3:0]  s_ack_i, s_err_i;
   logic [127:0] s_dat_i;
   logic [1:0]  grant_o;
   logic        bus_err_o;
   logic [1:0]  err_cause_o;
   logic [31:0] err_adr_o;

   logic [3:0]  ack_en, ack_force, err_force;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign s_ack_i = (s_stb_o & ack_en) | ack_force;
   assign s_err_i = err_force;
   assign s_dat_i = {32'h5A00_0003, 32'h5A00_0002, 32'h5A00_0001, 32'h5A00_0000};

   wb_shared_bus #(
      .N_MASTERS(2),
      .N_SLAVES(4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .bus_err_o(bus_err_o),
      .err_cause_o(err_cause_o), .err_adr_o(err_adr_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] adr;
      logic        we;
      logic [3:0]  exp_stb;
      logic        exp_ack;
      logic [31:0] exp_dat;
      logic        exp_miss;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0] acks;
      int exp_g[7];

      vecs[0] = '{32'h0000_0010, 1'b1, 4'b0001, 1'b1, 32'h5A00_0000, 1'b0};
      vecs[1] = '{32'h0000_7FFC, 1'b0, 4'b0001, 1'b1, 32'h5A00_0000, 1'b0};
      vecs[2] = '{32'h0000_8000, 1'b0, 4'b0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[3] = '{32'h0000_9004, 1'b1, 4'b0010, 1'b1, 32'h5A00_0001, 1'b0};
      vecs[4] = '{32'h0000_9104, 1'b0, 4'b0100, 1'b1, 32'h5A00_0002, 1'b0};
      vecs[5] = '{32'h0000_92FC, 1'b0, 4'b1000, 1'b1, 32'h5A00_0003, 1'b0};
      vecs[6] = '{32'h0000_9300, 1'b0, 4'b0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[7] = '{32'h0000_A000, 1'b0, 4'b0000, 1'b0, 32'h0000_0000, 1'b1};
      exp_g = '{1, 0, 2, 0, 1, 0, 2};

      resetn = 1'b0;
      m_cyc = '0; m_stb = '0; m_we = '0;
      m_adr = '0; m_dat = '0; m_sel = '0;
      ack_en = 4'b1111; ack_force = '0; err_force = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_grant", grant_o, 0);
      chk("rst_s_cyc", s_cyc_o, 0);
      chk("rst_m_ack", m_ack_o, 0);
      chk("rst_bus_err", bus_err_o, 0);
      chk("rst_cause", err_cause_o, 0);
      chk("rst_err_adr", err_adr_o, 0);
      resetn = 1'b1;
      @(negedge clk);

      // Decode table, master 0 only
      for (int v = 0; v < 8; v++) begin
         m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = vecs[v].we;
         m_adr[31:0] = vecs[v].adr; m_dat[31:0] = 32'hDEAD_BEEF; m_sel[3:0] = 4'hF;
         @(negedge clk);
         chk("dec_grant", grant_o, 1);
         chk("dec_s_stb", s_stb_o, vecs[v].exp_stb);
         chk("dec_s_cyc", s_cyc_o, vecs[v].exp_stb);
         chk("dec_m_ack", m_ack_o, {1'b0, vecs[v].exp_ack});
         chk("dec_m_dat", m_dat_o, vecs[v].exp_dat);
         chk("dec_s_adr", s_adr_o, vecs[v].adr);
         chk("dec_s_dat", s_dat_o, 32'hDEAD_BEEF);
         chk("dec_s_sel", s_sel_o, 4'hF);
         chk("dec_s_we", s_we_o, vecs[v].we);
         chk("dec_m_err0", m_err_o, 0);
         if (vecs[v].exp_miss) begin
            @(negedge clk);
            chk("miss_m_err", m_err_o, 1);
            chk("miss_bus_err", bus_err_o, 1);
            chk("miss_cause", err_cause_o, 2'b01);
            chk("miss_adr", err_adr_o, vecs[v].adr);
            chk("miss_s_stb", s_stb_o, 0);
         end
         m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
         @(negedge clk);
         chk("rel_grant", grant_o, 0);
         chk("rel_bus_err", bus_err_o, 0);
         chk("rel_s_cyc", s_cyc_o, 0);
      end

      // Slave error passes straight through without an interconnect error
      ack_en = 4'b1101; err_force = 4'b0010;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[31:0] = 32'h0000_9004;
      @(negedge clk);
      chk("serr_m_err", m_err_o, 1);
      chk("serr_m_ack", m_ack_o, 0);
      chk("serr_bus_err", bus_err_o, 0);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; err_force = '0;
      @(negedge clk);

      // Timeout: slave 2 never answers
      ack_en = 4'b1011;
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h0000_9104;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("tmo_wait_err", m_err_o, 0);
         chk("tmo_wait_stb", s_stb_o, 4'b0100);
      end
      @(negedge clk);
      chk("tmo_m_err", m_err_o, 1);
      chk("tmo_bus_err", bus_err_o, 1);
      chk("tmo_s_stb", s_stb_o, 0);
      chk("tmo_s_cyc", s_cyc_o, 4'b0100);
      chk("tmo_cause", err_cause_o, 2'b10);
      chk("tmo_adr", err_adr_o, 32'h0000_9104);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      @(negedge clk);
      chk("tmo_pulse_end", bus_err_o, 0);

      // Ack on the threshold cycle wins over the timeout
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      for (int k = 1; k <= 7; k++) @(negedge clk);
      @(negedge clk);
      ack_force = 4'b0100;
      #1;
      chk("thr_m_ack", m_ack_o, 1);
      @(negedge clk);
      chk("thr_m_err", m_err_o, 0);
      chk("thr_bus_err", bus_err_o, 0);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; ack_force = '0;
      @(negedge clk);
      chk("thr_bus_err2", bus_err_o, 0);
      chk("thr_cause_hold", err_cause_o, 2'b10);
      ack_en = 4'b1111;

      // Reset while master 1 owns the bus
      m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[63:32] = 32'h0000_9004;
      @(negedge clk);
      chk("m1_grant", grant_o, 2);
      chk("m1_s_stb", s_stb_o, 4'b0010);
      chk("m1_m_ack", m_ack_o, 2);
      #2 resetn = 1'b0;
      #1;
      chk("arst_grant", grant_o, 0);
      chk("arst_s_stb", s_stb_o, 0);
      chk("arst_s_cyc", s_cyc_o, 0);
      chk("arst_m_ack", m_ack_o, 0);
      chk("arst_m_dat", m_dat_o, 0);
      chk("arst_s_adr", s_adr_o, 0);
      chk("arst_cause", err_cause_o, 0);
      chk("arst_err_adr", err_adr_o, 0);
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[31:0] = 32'h0000_0010;
      @(negedge clk);
      resetn = 1'b1;

      // Round robin: each master drops cyc for one cycle after its ack
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("rr_grant", grant_o, exp_g[c]);
         chk("rr_m_ack", m_ack_o, exp_g[c]);
         acks = m_ack_o;
         m_cyc = ~acks;
         m_stb = ~acks;
      end
      m_cyc = '0; m_stb = '0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_shared_bus.md
# wb_shared_bus

Parametrised Wishbone B4 (classic) shared-bus interconnect that replaces the fixed single-master, four-slave decoder in the tiny SoC. It connects `N_MASTERS` masters (CPU, future DMA/debug) to `N_SLAVES` slaves through a round-robin arbiter. Slave decode uses base/mask pairs. The block returns a bus error for unmapped addresses and for slaves that fail to respond within a programmable timeout, and records the last error for software.

## Interface
Parameters:
- `N_MASTERS`, 2: number of master ports (1..8).
- `N_SLAVES`, 4: number of slave ports (1..16).
- `SLAVE_BASE`, {0x9200, 0x9100, 0x9000, 0x0000}: flat `N_SLAVES*32` base addresses; slave i occupies bits `[32*i +: 32]`.
- `SLAVE_MASK`, {0xFFFFFF00, 0xFFFFFF00, 0xFFFFFF00, 0xFFFF8000}: flat `N_SLAVES*32` decode masks.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles a strobe may wait without ack/err; 0 disables the timeout; maximum value 65535.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `m_cyc_i`, `m_stb_i`, `m_we_i`  in  `N_MASTERS`  per-master cycle, strobe and write enable.
- `m_adr_i`, `m_dat_i`  in  `N_MASTERS*32`  per-master address and write data.
- `m_sel_i`  in  `N_MASTERS*4`  per-master byte selects.
- `m_ack_o`, `m_err_o`  out  `N_MASTERS`  per-master ack and error.
- `m_dat_o`  out  32  read data, broadcast to all masters.
- `s_cyc_o`, `s_stb_o`  out  `N_SLAVES`  per-slave cycle and strobe; only the selected slave is driven.
- `s_we_o`  out  1, `s_adr_o`  out  32, `s_dat_o`  out  32, `s_sel_o`  out  4: broadcast from the bus owner.
- `s_ack_i`, `s_err_i`  in  `N_SLAVES`  per-slave ack and error.
- `s_dat_i`  in  `N_SLAVES*32`  per-slave read data.
- `grant_o`  out  `N_MASTERS`  one-hot current owner; 0 when the bus is idle.
- `bus_err_o`  out  1  one-cycle pulse when the interconnect itself generates an error.
- `err_cause_o`  out  2  cause of the last generated error: 01 = decode miss, 10 = timeout.
- `err_adr_o`  out  32  address of the last generated error.

## Operation
- FSM states: IDLE and BUSY. `owner` is a register; `last` (index of the previous owner) resets to `N_MASTERS-1`, so master 0 has first priority after reset.
- IDLE: if any `m_cyc_i` is high, the block grants the first requesting index searching from `last+1` upward, wrapping at `N_MASTERS`. It sets `owner`, sets `last` to the winner, and enters BUSY. All slave `cyc`/`stb` outputs stay 0 while in IDLE.
- BUSY: the owner's `we`/`adr`/`dat`/`sel` drive the `s_*` broadcast outputs.
  - Decode is combinational on the owner's address: slave i is hit when `(adr & MASK_i) == BASE_i`. On overlapping regions the lowest index wins.
  - `s_cyc_o[i] = owner cyc & hit_i`; `s_stb_o[i] = owner stb & hit_i & ~err_r`.
- Responses in BUSY:
  - `m_ack_o[owner] = s_ack_i[hit]` and `m_dat_o = s_dat_i[hit]`, both combinational.
  - `m_err_o[owner] = s_err_i[hit] | err_r`.
  - Non-owners always receive `ack = err = 0`.
  - `m_dat_o` is 0 when no slave is hit.
- Decode miss: owner `stb` high with no hit and `err_r` = 0 sets `err_r` = 1 on the next edge, with cause 01.
- Timeout counter (16 bit):
  - Increments each BUSY cycle in which the owner `stb` is high, a slave is hit, and the slave gives no ack/err.
  - Clears on slave ack/err, on `stb` low, or on entering IDLE.
  - When it equals `TIMEOUT_CYCLES-1` and is incrementing, `err_r` is set next cycle with cause 10.
- `err_r` is a one-cycle pulse and clears on the following edge.
  - While `err_r` is high, slave `stb` is gated off, so the slave cannot complete the access.
  - `bus_err_o = err_r`.
  - `err_cause_o` and `err_adr_o` update on the same edge that sets `err_r` and hold until the next generated error.
- Release: owner `cyc` low in BUSY causes the next state to be IDLE and clears `err_r`. The block re-arbitrates in IDLE.

## Timing
- Reset values: every output is 0. `owner` = 0, `last` = `N_MASTERS-1`, counter = 0, state = IDLE.
- Grant latency: the request is seen in IDLE in cycle 0. `grant_o` and the slave `cyc`/`stb` appear in cycle 1.
- Slave ack/err and read data reach the master in the same cycle (zero added latency).
- Bus turnaround: at least one IDLE cycle between owners, and between consecutive cycles of the same master.
- Decode-miss error: asserted 1 cycle after the strobe is seen in BUSY.
- Timeout error: asserted `TIMEOUT_CYCLES` cycles after the strobe is first seen in BUSY.
- Slave ack in the same cycle as the timeout threshold: the ack wins and no error is generated.
- Reset mid-transfer: all outputs drop asynchronously. After reset release the FSM is in IDLE.

## Test plan
- Single master, default map: M0 writes 0xDEADBEEF to 0x0000_0010 with `sel` = 0xF. Required: slave 0 sees `stb` in cycle 1; ack is returned the same cycle; `grant_o` = 01.
- Round robin: M0 and M1 hold `cyc` continuously, each doing back-to-back single cycles. Required: grants alternate 01, 10, 01, with one IDLE cycle between each.
- Decode miss: M0 reads 0x0000_A000. Required: no slave `stb`; `m_err_o[0]` is high 1 cycle later; `err_cause_o` = 01; `err_adr_o` = 0xA000; `bus_err_o` pulses for one cycle.
- Timeout: `TIMEOUT_CYCLES` = 8 and slave 2 never acks an access to 0x9104. Required: `m_err_o[0]` is asserted 8 cycles after the strobe; `s_stb_o[2]` is low during the error cycle; `err_cause_o` = 10.
- Ack at the threshold: slave 2 acks exactly on cycle 7 of the wait. Required: normal ack, no error, `bus_err_o` stays 0.
- Reset mid-access: `resetn` is pulled low while M1 owns the bus. Required: all outputs are 0 immediately. After release, a simultaneous request from M0 and M1 grants M0 first.
